// File: rtl/imm_pkg.sv
// Shared definitions for the immediate encoder/decoder pair: format codes,
// field widths and the pipeline payload structs.
package imm_pkg;

    localparam int unsigned XLEN   = 32;
    localparam int unsigned INST_W = 25;
    localparam int unsigned SEL_W  = 3;

    typedef enum logic [SEL_W-1:0] {
        IMM_NONE    = 3'd0,
        IMM_I       = 3'd1,
        IMM_SHAMT   = 3'd2,
        IMM_S       = 3'd3,
        IMM_B       = 3'd4,
        IMM_U       = 3'd5,
        IMM_J       = 3'd6,
        IMM_ILLEGAL = 3'd7
    } imm_sel_e;

    typedef struct packed {
        imm_sel_e            sel;
        logic [XLEN-1:0]     imm;
        logic [INST_W-1:0]   base;
    } enc_req_t;

    typedef struct packed {
        logic [INST_W-1:0]   inst;
        logic                err;
    } enc_rsp_t;

    // True when v[XLEN-1:lsb] are all equal, i.e. v sign-extends from bit lsb.
    function automatic logic fits_signed(input logic [XLEN-1:0] v, input int unsigned lsb);
        logic [XLEN-1:0] t;
        t = XLEN'($signed(v) >>> lsb);
        return (t == '0) || (&t);
    endfunction

endpackage

// File: rtl/imm_pack.sv
// Scatters an immediate into the inst[31:7] field for the selected format and
// flags values the format cannot represent.
module imm_pack
    import imm_pkg::*;
(
    input  logic [SEL_W-1:0]  ImmSel,
    input  logic [XLEN-1:0]   imm,
    input  logic [INST_W-1:0] base_inst,
    output logic [INST_W-1:0] inst,
    output logic              err
);

    always_comb begin
        inst = base_inst;
        err  = 1'b0;
        case (imm_sel_e'(ImmSel))
            IMM_NONE: begin
                err = |imm;
            end
            IMM_I: begin
                inst[24:13] = imm[11:0];
                err         = !fits_signed(imm, 11);
            end
            IMM_SHAMT: begin
                inst[17:13] = imm[4:0];
                err         = |imm[31:5];
            end
            IMM_S: begin
                inst[24:18] = imm[11:5];
                inst[4:0]   = imm[4:0];
                err         = !fits_signed(imm, 11);
            end
            IMM_B: begin
                inst[24]    = imm[12];
                inst[0]     = imm[11];
                inst[23:18] = imm[10:5];
                inst[4:1]   = imm[4:1];
                err         = imm[0] || !fits_signed(imm, 12);
            end
            IMM_U: begin
                inst[24:5] = imm[31:12];
                err        = |imm[11:0];
            end
            IMM_J: begin
                inst[24]    = imm[20];
                inst[12:5]  = imm[19:12];
                inst[13]    = imm[11];
                inst[23:14] = imm[10:1];
                err         = imm[0] || !fits_signed(imm, 20);
            end
            default: begin
                err = 1'b1;
            end
        endcase
    end

endmodule

// File: rtl/imm_encoder.sv
// Two-stage elastic immediate encoder: stage 1 holds the request, stage 2 the
// packed field, plus a saturating count of errored results handed downstream.
module imm_encoder
    import imm_pkg::*;
#(
    parameter int unsigned ERR_CNT_W = 16,
    parameter bit          CHECK_EN  = 1'b1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [SEL_W-1:0]     ImmSel,
    input  logic [XLEN-1:0]      imm,
    input  logic [INST_W-1:0]    base_inst,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [INST_W-1:0]    inst,
    output logic                 err,
    output logic [ERR_CNT_W-1:0] err_cnt
);

    logic                 s1_valid_q;
    enc_req_t             s1_req_q;
    logic                 s2_valid_q;
    enc_rsp_t             s2_rsp_q;
    logic [ERR_CNT_W-1:0] err_cnt_q;
    logic [ERR_CNT_W-1:0] err_cnt_d;

    logic                 s2_adv_c;
    logic [INST_W-1:0]    pack_inst_c;
    logic                 pack_err_c;
    enc_rsp_t             s2_rsp_d;

    assign s2_adv_c = !s2_valid_q || out_ready;
    assign in_ready = !s1_valid_q || s2_adv_c;

    imm_pack u_pack (
        .ImmSel    (s1_req_q.sel),
        .imm       (s1_req_q.imm),
        .base_inst (s1_req_q.base),
        .inst      (pack_inst_c),
        .err       (pack_err_c)
    );

    always_comb begin
        s2_rsp_d      = '0;
        s2_rsp_d.inst = pack_inst_c;
        s2_rsp_d.err  = CHECK_EN && pack_err_c;
    end

    // Count errored results as they are handed off, sticking at all-ones.
    always_comb begin
        err_cnt_d = err_cnt_q;
        if (s2_valid_q && out_ready && s2_rsp_q.err && (err_cnt_q != '1)) begin
            err_cnt_d = err_cnt_q + ERR_CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid_q <= 1'b0;
            s1_req_q   <= '0;
            s2_valid_q <= 1'b0;
            s2_rsp_q   <= '0;
            err_cnt_q  <= '0;
        end else begin
            if (in_ready) begin
                s1_valid_q <= in_valid;
                if (in_valid) begin
                    s1_req_q.sel  <= imm_sel_e'(ImmSel);
                    s1_req_q.imm  <= imm;
                    s1_req_q.base <= base_inst;
                end
            end
            if (s2_adv_c) begin
                s2_valid_q <= s1_valid_q;
                if (s1_valid_q) begin
                    s2_rsp_q <= s2_rsp_d;
                end
            end
            err_cnt_q <= err_cnt_d;
        end
    end

    assign out_valid = s2_valid_q;
    assign inst      = s2_rsp_q.inst;
    assign err       = s2_rsp_q.err;
    assign err_cnt   = err_cnt_q;

endmodule

// File: doc/imm_encoder.md
Name: imm_encoder

Overview:
- Inverse of the immediate generator: takes a 32-bit immediate plus an ImmSel format code and scatters its bits into the 25-bit instruction field (inst[31:7] as bits 24:0), merged over a caller-supplied base field.
- Flags immediates that the selected format cannot represent.
- Two-stage elastic valid/ready pipeline used by the trace/replay instruction builder and by the decode round-trip checker.
- Keeps a saturating count of errored transactions.

Parameters:
- ERR_CNT_W, 16, width of saturating error counter
- CHECK_EN, 1, 1 = compute range error; 0 = err output tied 0 and counter never increments

Ports:
- clk  input  1  clock
- rst  input  1  synchronous active-high reset
- in_valid  input  1  request valid
- in_ready  output  1  encoder can accept this cycle
- ImmSel  input  3  format code, same encoding as decoder
- imm  input  32  immediate to encode
- base_inst  input  25  non-immediate bits; immediate positions are overwritten
- out_valid  output  1  result valid
- out_ready  input  1  consumer accepts
- inst  output  25  encoded field
- err  output  1  immediate not representable or illegal ImmSel
- err_cnt  output  ERR_CNT_W  saturating count of err=1 outputs handshaken

Behaviour:
- Reset (clk edge with rst=1): both stage valids 0, out_valid=0, inst=0, err=0, err_cnt=0. in_ready is 1 in the first cycle after reset. Reset mid-operation drops in-flight entries with no output.
- Stage 1 registers the inputs on in_valid&&in_ready. Stage 2 registers the packed inst/err. out_valid/inst/err come from stage 2 flops.
- Latency: accept at edge N gives out_valid at edge N+2 when not stalled. Full throughput of one per cycle.
- Ready logic:
  - s2 advances when !s2_valid || out_ready.
  - s1 advances into s2 when s2 advances.
  - in_ready = !s1_valid || s2 advances.
  - No combinational path from in_valid to out_valid. in_ready depends combinationally on out_ready.
- Outputs hold stable while out_valid && !out_ready. Order is preserved and nothing is lost or duplicated.
- Packing per ImmSel. All unnamed bits come from base_inst.
  - 000: inst = base_inst; err = (imm != 0).
  - 001 I: inst[24:13] = imm[11:0]; err unless imm[31:11] all equal.
  - 010 shamt: inst[17:13] = imm[4:0]; err unless imm[31:5] == 0.
  - 011 S: inst[24:18] = imm[11:5], inst[4:0] = imm[4:0]; err as I.
  - 100 B: inst[24] = imm[12], inst[0] = imm[11], inst[23:18] = imm[10:5], inst[4:1] = imm[4:1]; err if imm[0] or imm[31:12] not all equal.
  - 101 U: inst[24:5] = imm[31:12]; err if imm[11:0] != 0.
  - 110 J: inst[24] = imm[20], inst[12:5] = imm[19:12], inst[13] = imm[11], inst[23:14] = imm[10:1]; err if imm[0] or imm[31:20] not all equal.
  - 111: inst = base_inst; err = 1.
- Error handling:
  - On err, inst is still packed from the truncated bits.
  - Round-trip invariant: decode(encode(imm)) == imm whenever err = 0.
- err_cnt increments on out_valid && out_ready && err and saturates at all-ones.

Decomposition:
- Shared package imm_pkg holds:
  - ImmSel enum (IMM_NONE, IMM_I, IMM_SHAMT, IMM_S, IMM_B, IMM_U, IMM_J), shared with the decoder.
  - Widths INST_W=25 and XLEN=32.
- One combinational sub-module, imm_pack (ImmSel, imm, base_inst -> inst, err), instantiated between stage 1 and stage 2. The pipeline and counter stay in imm_encoder.

Test Plan:
- I-type: ImmSel=001, imm=0xFFFFFFFF, base=0 -> inst=0x1FFE000, err=0, out_valid two cycles after accept.
- B-type: ImmSel=100, imm=0x00000FFE, base=0 -> inst=0x0FC001F, err=0. Then imm=0x3 -> err=1, err_cnt=1.
- U and shamt: ImmSel=101, imm=0x12345000 -> inst=0x02468A0, err=0. ImmSel=010, imm=32 -> err=1.
- Backpressure: out_ready=0, send 3 back-to-back requests -> in_ready drops after 2 accepts. Release out_ready -> 3 outputs in order, held stable while stalled.
- Round-trip: 10k random imm per format, each encode error-free, fed through the decoder -> decoded value equals imm. Illegal ImmSel=111 -> err=1. err_cnt saturates at 0xFFFF with ERR_CNT_W=16.
- Reset mid-stream: rst with both stages full -> next cycle out_valid=0, err_cnt=0, in_ready=1, no stale output afterwards.
